// File: rtl/disp_pkg.sv
// Shared types and constants for the display fetch path: FSM state encoding,
// AXI read-channel constants and the default frame geometry.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_BUF = 2'd1,
    ADDR     = 2'd2,
    DATA     = 2'd3
  } disp_state_e;

  localparam logic [2:0] ARSIZE_8B    = 3'b011;
  localparam logic [1:0] ARBURST_INCR = 2'b01;
  localparam logic [1:0] RRESP_OKAY   = 2'b00;

  localparam int unsigned H_PIXELS        = 640;
  localparam int unsigned V_LINES         = 480;
  localparam int unsigned PIX_PER_WORD    = 2;
  localparam int unsigned DEF_FRAME_WORDS = H_PIXELS * V_LINES / PIX_PER_WORD;
  localparam int unsigned DEF_BURST_LEN   = 16;

endpackage

// File: rtl/disp_fetch.sv
// Frame fetch engine: AXI4 read master that streams one frame from VRAM in
// fixed INCR bursts into the display pixel FIFO, paced by BUF_WREADY.
module disp_fetch
  import disp_pkg::*;
#(
  parameter int unsigned FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int unsigned BURST_LEN   = DEF_BURST_LEN
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        DISPON,
  input  logic [31:0] DISPADDR,
  input  logic        FRAME_START,
  input  logic        BUF_WREADY,
  output logic [63:0] FIFOIN,
  output logic        FIFOWR,
  output logic [31:0] ARADDR,
  output logic [7:0]  ARLEN,
  output logic [2:0]  ARSIZE,
  output logic [1:0]  ARBURST,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [63:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RLAST,
  input  logic        RVALID,
  output logic        RREADY,
  output logic        BUSY,
  output logic        FETCH_LATE,
  output logic        RD_ERR,
  output disp_state_e dbg_state
);

  localparam int unsigned NBURSTS      = FRAME_WORDS / BURST_LEN;
  localparam int unsigned CNT_W        = $clog2(NBURSTS) + 1;
  localparam logic [31:0] ADDR_STEP    = 32'(BURST_LEN * 8);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(NBURSTS);

  // Handshake rule on both AR and R: a transfer happens on a rising ACLK edge
  // where VALID and READY are both high; the master holds ARVALID/ARADDR
  // stable until ARREADY, and RREADY is held high for the whole DATA state.

  disp_state_e      state;
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] burst_cnt_nxt;
  logic             r_hs;
  logic             unused_addr_bits;

  assign ARLEN            = 8'(BURST_LEN - 1);
  assign ARSIZE           = ARSIZE_8B;
  assign ARBURST          = ARBURST_INCR;
  assign dbg_state        = state;
  assign unused_addr_bits = ^DISPADDR[6:0];

  always_comb begin
    burst_cnt_nxt = burst_cnt + 1'b1;
    r_hs          = RVALID && RREADY;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state      <= IDLE;
      burst_cnt  <= '0;
      ARADDR     <= '0;
      ARVALID    <= 1'b0;
      RREADY     <= 1'b0;
      FIFOWR     <= 1'b0;
      FIFOIN     <= '0;
      BUSY       <= 1'b0;
      FETCH_LATE <= 1'b0;
      RD_ERR     <= 1'b0;
    end else begin
      // Every accepted beat goes to the FIFO, including error beats.
      FIFOWR <= r_hs;
      if (r_hs) begin
        FIFOIN <= RDATA;
        if (RRESP != RRESP_OKAY) RD_ERR <= 1'b1;
      end
      if (FRAME_START && state != IDLE) FETCH_LATE <= 1'b1;

      case (state)
        IDLE: begin
          if (FRAME_START && DISPON) begin
            ARADDR    <= {DISPADDR[31:7], 7'b0};
            burst_cnt <= '0;
            BUSY      <= 1'b1;
            state     <= WAIT_BUF;
          end
        end
        WAIT_BUF: begin
          if (!DISPON) begin
            BUSY  <= 1'b0;
            state <= IDLE;
          end else if (BUF_WREADY) begin
            ARVALID <= 1'b1;
            state   <= ADDR;
          end
        end
        ADDR: begin
          if (ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state   <= DATA;
          end
        end
        DATA: begin
          // A burst cannot be aborted, so DISPON is only honoured at its end.
          if (r_hs && RLAST) begin
            RREADY    <= 1'b0;
            burst_cnt <= burst_cnt_nxt;
            ARADDR    <= ARADDR + ADDR_STEP;
            if (burst_cnt_nxt == CNT_END || !DISPON) begin
              BUSY  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= WAIT_BUF;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_disp_fetch.sv
// Directed bench for disp_fetch: table-driven frame fetches against an AXI
// slave/FIFO model, plus hand-written pacing, DISPON, late-frame and reset cases.
module tb_disp_fetch;
  import disp_pkg::*;

  localparam int unsigned FW = 64;
  localparam int unsigned BL = 16;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        DISPON = 1'b1;
  logic [31:0] DISPADDR = '0;
  logic        FRAME_START = 1'b0;
  logic        BUF_WREADY = 1'b1;
  logic [63:0] FIFOIN;
  logic        FIFOWR;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY = 1'b0;
  logic [63:0] RDATA = '0;
  logic [1:0]  RRESP = '0;
  logic        RLAST = 1'b0;
  logic        RVALID = 1'b0;
  logic        RREADY;
  logic        BUSY;
  logic        FETCH_LATE;
  logic        RD_ERR;
  disp_state_e dbg_state;

  disp_fetch #(.FRAME_WORDS(FW), .BURST_LEN(BL)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .DISPON(DISPON), .DISPADDR(DISPADDR),
    .FRAME_START(FRAME_START), .BUF_WREADY(BUF_WREADY), .FIFOIN(FIFOIN),
    .FIFOWR(FIFOWR), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY), .RDATA(RDATA),
    .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .BUSY(BUSY), .FETCH_LATE(FETCH_LATE), .RD_ERR(RD_ERR), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 ACLK = ~ACLK;

  // ---------------- scoreboard / slave state ----------------
  logic [63:0] exp_q[$];
  logic [31:0] ar_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          wr_count = 0;
  int          beat_total = 0;
  int          ar_delay = 0;
  int          ar_wait = 0;
  bit          gap_en = 1'b0;
  int          err_beat = -1;
  bit          r_active = 1'b0;
  int          r_beat = 0;
  logic [31:0] s_addr = '0;
  bit          prev_wait = 1'b0;
  logic [31:0] prev_araddr = '0;

  typedef struct {
    logic [31:0] dispaddr;
    int          ar_delay;
    bit          gap_en;
    int          err_beat;
    logic [31:0] exp_base;
    int          exp_writes;
    logic        exp_rd_err;
  } vec_t;
  vec_t vecs[4];

  function automatic logic [63:0] pattern(input logic [31:0] a);
    return {a ^ 32'hDEAD_BEEF, a};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // One clock cycle: sample DUT at the falling edge, then drive slave inputs
  // for the next rising edge.
  task automatic tick();
    @(negedge ACLK);
    if (!ARESETN) begin
      exp_q.delete();
      ar_q.delete();
      wr_count = 0; beat_total = 0; ar_wait = 0;
      r_active = 1'b0; r_beat = 0; prev_wait = 1'b0;
      ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RRESP = '0;
      return;
    end
    if (FIFOWR) begin
      wr_count++;
      if (exp_q.size() == 0) check("fifo_extra_write", 64'd1, 64'd0);
      else check("fifo_data", FIFOIN, exp_q.pop_front());
    end
    if (prev_wait) begin
      check("arvalid_held", {63'd0, ARVALID}, 64'd1);
      check("araddr_stable", {32'd0, ARADDR}, {32'd0, prev_araddr});
    end
    RVALID = 1'b0; RLAST = 1'b0; RRESP = '0;
    if (r_active && RREADY) begin
      if (!gap_en || $urandom_range(0, 2) != 0) begin
        RVALID = 1'b1;
        RDATA  = pattern(s_addr + 32'(r_beat * 8));
        RRESP  = (beat_total == err_beat) ? 2'b10 : 2'b00;
        RLAST  = (r_beat == BL - 1);
        exp_q.push_back(RDATA);
        beat_total++;
        r_beat++;
        if (RLAST) r_active = 1'b0;
      end
    end
    ARREADY = 1'b0;
    if (ARVALID && !r_active) begin
      if (ar_wait >= ar_delay) begin
        ARREADY = 1'b1;
        ar_q.push_back(ARADDR);
        s_addr = ARADDR;
        r_active = 1'b1;
        r_beat = 0;
        ar_wait = 0;
      end else begin
        ar_wait++;
      end
    end
    prev_wait   = ARVALID && !ARREADY;
    prev_araddr = ARADDR;
  endtask

  task automatic do_reset();
    ARESETN = 1'b0;
    tick();
    tick();
    ARESETN = 1'b1;
    tick();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_arvalid"}, {63'd0, ARVALID}, 64'd0);
    check({tag, "_rready"}, {63'd0, RREADY}, 64'd0);
    check({tag, "_fifowr"}, {63'd0, FIFOWR}, 64'd0);
    check({tag, "_fifoin"}, FIFOIN, 64'd0);
    check({tag, "_araddr"}, {32'd0, ARADDR}, 64'd0);
    check({tag, "_busy"}, {63'd0, BUSY}, 64'd0);
    check({tag, "_fetch_late"}, {63'd0, FETCH_LATE}, 64'd0);
    check({tag, "_rd_err"}, {63'd0, RD_ERR}, 64'd0);
    check({tag, "_state"}, {62'd0, dbg_state}, {62'd0, IDLE});
  endtask

  task automatic start_frame(input logic [31:0] addr);
    DISPADDR = addr;
    FRAME_START = 1'b1;
    tick();
    FRAME_START = 1'b0;
    check("start_state_wait_buf", {62'd0, dbg_state}, {62'd0, WAIT_BUF});
    check("start_busy", {63'd0, BUSY}, 64'd1);
    check("start_arvalid_low", {63'd0, ARVALID}, 64'd0);
    tick();
    check("start_arvalid_t2", {63'd0, ARVALID}, 64'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (BUSY && n < budget) begin
      tick();
      n++;
    end
    check("idle_timeout", {63'd0, BUSY}, 64'd0);
  endtask

  task automatic wait_ar(input int count);
    for (int n = 0; n < 500 && ar_q.size() < count; n++) tick();
    check("wait_ar_timeout", 64'(ar_q.size() >= count), 64'd1);
  endtask

  task automatic wait_wr(input int count);
    for (int n = 0; n < 1000 && wr_count < count; n++) tick();
    check("wait_wr_timeout", 64'(wr_count >= count), 64'd1);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [31:0] got_a;
    bit          seen;

    vecs[0] = '{32'h1000_0045, 0, 1'b0, -1, 32'h1000_0000, 64, 1'b0};
    vecs[1] = '{32'h2345_67FF, 5, 1'b1, -1, 32'h2345_6780, 64, 1'b0};
    vecs[2] = '{32'hFFFF_FF80, 0, 1'b0, -1, 32'hFFFF_FF80, 64, 1'b0};
    vecs[3] = '{32'h0000_0000, 2, 1'b1,  3, 32'h0000_0000, 64, 1'b1};

    tick();
    check_reset_vals("rst");
    check("rst_arlen", {56'd0, ARLEN}, 64'd15);
    check("rst_arsize", {61'd0, ARSIZE}, 64'd3);
    check("rst_arburst", {62'd0, ARBURST}, 64'd1);

    for (int v = 0; v < 4; v++) begin
      ar_delay = vecs[v].ar_delay;
      gap_en   = vecs[v].gap_en;
      err_beat = vecs[v].err_beat;
      do_reset();
      start_frame(vecs[v].dispaddr);
      wait_idle(3000);
      check("vec_busy_fall_writes", 64'(wr_count), 64'(vecs[v].exp_writes));
      check("vec_ar_count", 64'(ar_q.size()), 64'd4);
      for (int k = 0; k < 4; k++) begin
        got_a = (k < ar_q.size()) ? ar_q[k] : 32'hxxxx_xxxx;
        check("vec_araddr", {32'd0, got_a}, {32'd0, vecs[v].exp_base + 32'(k * 128)});
      end
      check("vec_rd_err", {63'd0, RD_ERR}, {63'd0, vecs[v].exp_rd_err});
      check("vec_fetch_late", {63'd0, FETCH_LATE}, 64'd0);
      check("vec_state_idle", {62'd0, dbg_state}, {62'd0, IDLE});
      tick();
      check("vec_exp_q_empty", 64'(exp_q.size()), 64'd0);
    end

    // Pacing: hold BUF_WREADY low for 50 cycles after burst 1.
    ar_delay = 0; gap_en = 1'b0; err_beat = -1;
    do_reset();
    start_frame(32'h4000_0000);
    wait_ar(1);
    BUF_WREADY = 1'b0;
    wait_wr(16);
    seen = 1'b0;
    for (int n = 0; n < 50; n++) begin
      tick();
      if (ARVALID) seen = 1'b1;
    end
    check("pace_arvalid_held_low", {63'd0, seen}, 64'd0);
    check("pace_state_wait_buf", {62'd0, dbg_state}, {62'd0, WAIT_BUF});
    BUF_WREADY = 1'b1;
    tick();
    check("pace_arvalid_after_ready", {63'd0, ARVALID}, 64'd1);
    check("pace_araddr_burst2", {32'd0, ARADDR}, 64'h4000_0080);
    wait_idle(1000);
    check("pace_writes", 64'(wr_count), 64'd64);

    // DISPON dropped during burst 2: burst completes, nothing more issued.
    do_reset();
    start_frame(32'h0000_1000);
    wait_ar(2);
    wait_wr(20);
    DISPON = 1'b0;
    wait_idle(1000);
    check("dispon_writes", 64'(wr_count), 64'd32);
    check("dispon_state_idle", {62'd0, dbg_state}, {62'd0, IDLE});
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (ARVALID) seen = 1'b1;
    end
    check("dispon_no_arvalid", {63'd0, seen}, 64'd0);
    check("dispon_ar_count", 64'(ar_q.size()), 64'd2);
    DISPON = 1'b1;

    // Late FRAME_START while busy: flagged, frame finishes, no restart.
    do_reset();
    start_frame(32'h0000_2000);
    wait_ar(1);
    FRAME_START = 1'b1;
    tick();
    FRAME_START = 1'b0;
    check("late_fetch_late", {63'd0, FETCH_LATE}, 64'd1);
    wait_idle(1000);
    check("late_writes", 64'(wr_count), 64'd64);
    for (int n = 0; n < 10; n++) tick();
    check("late_no_restart_busy", {63'd0, BUSY}, 64'd0);
    check("late_ar_count", 64'(ar_q.size()), 64'd4);
    check("late_sticky", {63'd0, FETCH_LATE}, 64'd1);

    // Asynchronous reset mid-DATA with both sticky flags set.
    err_beat = 2;
    do_reset();
    start_frame(32'h0000_3000);
    wait_ar(2);
    FRAME_START = 1'b1;
    tick();
    FRAME_START = 1'b0;
    wait_wr(20);
    check("areset_pre_rd_err", {63'd0, RD_ERR}, 64'd1);
    check("areset_pre_state", {62'd0, dbg_state}, {62'd0, DATA});
    @(posedge ACLK);
    #2;
    ARESETN = 1'b0;
    #1;
    check_reset_vals("areset");
    tick();
    tick();
    ARESETN = 1'b1;
    tick();
    err_beat = -1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
